// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_checker
//  Purpose  : Self-synchronising serial checker for a two-tap Fibonacci LFSR
//             (PRBS) stream. Locks after a run of correct predictions, then
//             flags and counts bit errors until too many consecutive
//             mismatches force it back to search.
//  Revision : 1.0  initial release
// ============================================================================
module prbs_checker #(
    parameter int N          = 3,
    parameter int TAP_A      = 3,
    parameter int TAP_B      = 2,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    // Counter widths leave one spare bit so a threshold value is representable.
    localparam int c_FILL_W  = $clog2(N) + 1;
    localparam int c_MATCH_W = $clog2(LOCK_CNT) + 1;
    localparam int c_MISS_W  = $clog2(UNLOCK_CNT) + 1;

    localparam logic [0:0] c_ST_SEARCH = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    localparam logic [c_FILL_W-1:0]  c_FILL_FULL  = c_FILL_W'(N);
    localparam logic [c_FILL_W-1:0]  c_FILL_ONE   = c_FILL_W'(1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(LOCK_CNT - 1);
    localparam logic [c_MATCH_W-1:0] c_MATCH_ONE  = c_MATCH_W'(1);
    localparam logic [c_MISS_W-1:0]  c_MISS_LAST  = c_MISS_W'(UNLOCK_CNT - 1);
    localparam logic [c_MISS_W-1:0]  c_MISS_ONE   = c_MISS_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     c_CNT_ONE    = CNT_W'(1);

    // r_sr[1] holds the most recently received bit, r_sr[N] the oldest.
    logic [N:1]           r_sr;
    logic [c_FILL_W-1:0]  r_fill;
    logic [c_MATCH_W-1:0] r_match;
    logic [c_MISS_W-1:0]  r_miss;
    logic [0:0]           r_state;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic [CNT_W-1:0]     r_err_count;

    logic w_pred;
    logic w_mismatch;
    logic w_filled;
    logic w_sr_zero;
    logic w_err;

    // The prediction is taken from the history before the new bit enters it.
    assign w_pred     = r_sr[TAP_A] ^ r_sr[TAP_B];
    assign w_mismatch = bit_valid & (bit_in != w_pred);
    assign w_filled   = (r_fill == c_FILL_FULL);
    assign w_sr_zero  = (r_sr == '0);
    assign w_err      = (r_state == c_ST_LOCKED) & w_mismatch;

    // History shift register: every valid bit enters, correct or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr <= '0;
        end else if (bit_valid) begin
            r_sr <= {r_sr[N-1:1], bit_in};
        end
    end

    // Lock state machine with fill, match-run and miss-run counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_SEARCH;
            r_fill   <= '0;
            r_match  <= '0;
            r_miss   <= '0;
            r_locked <= 1'b0;
        end else if (bit_valid) begin
            case (r_state)
                c_ST_SEARCH: begin
                    if (!w_filled) begin
                        // History not yet meaningful: no prediction to judge.
                        r_fill <= r_fill + c_FILL_ONE;
                    end else if (w_sr_zero || w_mismatch) begin
                        // An all-zero history predicts zero trivially, so it
                        // never counts towards lock.
                        r_match <= '0;
                    end else if (r_match == c_MATCH_LAST) begin
                        r_state  <= c_ST_LOCKED;
                        r_locked <= 1'b1;
                        r_match  <= '0;
                    end else begin
                        r_match <= r_match + c_MATCH_ONE;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_mismatch) begin
                        if (r_miss == c_MISS_LAST) begin
                            // History is kept, so search resumes without refill.
                            r_state  <= c_ST_SEARCH;
                            r_locked <= 1'b0;
                            r_fill   <= c_FILL_FULL;
                            r_match  <= '0;
                            r_miss   <= '0;
                        end else begin
                            r_miss <= r_miss + c_MISS_ONE;
                        end
                    end else begin
                        r_miss <= '0;
                    end
                end
                default: begin
                    r_state  <= c_ST_SEARCH;
                    r_locked <= 1'b0;
                    r_fill   <= '0;
                    r_match  <= '0;
                    r_miss   <= '0;
                end
            endcase
        end
    end

    // One-cycle error flag for each mismatched bit seen while locked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
        end
    end

    // Saturating error counter; clear takes priority over a simultaneous error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (clear) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != c_CNT_MAX)) begin
            r_err_count <= r_err_count + c_CNT_ONE;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs_checker
//  Purpose  : Directed bench for prbs_checker. Two instances (16-bit and 2-bit
//             error counters) share one stimulus; a queue-based model of the
//             lock rules is compared against both on every falling edge, and
//             hand-derived expectations pin lock points and error totals.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prbs_checker;

    localparam int c_N          = 3;
    localparam int c_TAP_A      = 3;
    localparam int c_TAP_B      = 2;
    localparam int c_LOCK_CNT   = 8;
    localparam int c_UNLOCK_CNT = 4;
    localparam int c_MAX16      = 65535;
    localparam int c_MAX2       = 3;

    logic        clk;
    logic        reset_n;
    logic        bit_valid;
    logic        bit_in;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        locked2;
    logic        err_pulse2;
    logic [1:0]  err_count2;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    // Reference stream for seed 001, taps 3,2 (period 7).
    bit stream [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int ph;

    // Model state: received-bit history (index 0 = most recent).
    bit m_hist [$];
    bit m_locked;
    bit m_pulse;
    int m_fill, m_match, m_miss, m_cnt16, m_cnt2;

    prbs_checker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs_checker #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clear     (clear),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the lock/error rules, advanced per clock edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hist.delete();
            for (int k = 0; k < c_N; k++) m_hist.push_back(1'b0);
            m_locked = 1'b0; m_pulse = 1'b0;
            m_fill = 0; m_match = 0; m_miss = 0; m_cnt16 = 0; m_cnt2 = 0;
        end else begin
            bit pred, mis, zero;
            m_pulse = 1'b0;
            if (bit_valid) begin
                pred = m_hist[c_TAP_A-1] ^ m_hist[c_TAP_B-1];
                mis  = (bit_in != pred);
                zero = 1'b1;
                foreach (m_hist[k]) if (m_hist[k]) zero = 1'b0;
                if (!m_locked) begin
                    if (m_fill < c_N) m_fill++;
                    else if (zero || mis) m_match = 0;
                    else begin
                        m_match++;
                        if (m_match == c_LOCK_CNT) begin m_locked = 1'b1; m_match = 0; end
                    end
                end else if (mis) begin
                    m_pulse = 1'b1;
                    m_miss++;
                    if (m_miss == c_UNLOCK_CNT) begin
                        m_locked = 1'b0; m_miss = 0; m_match = 0; m_fill = c_N;
                    end
                end else begin
                    m_miss = 0;
                end
                m_hist.push_front(bit_in);
                void'(m_hist.pop_back());
            end
            if (clear) begin
                m_cnt16 = 0; m_cnt2 = 0;
            end else if (m_pulse) begin
                if (m_cnt16 < c_MAX16) m_cnt16++;
                if (m_cnt2 < c_MAX2) m_cnt2++;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",     int'(locked),     int'(m_locked));
            check("err_pulse",  int'(err_pulse),  int'(m_pulse));
            check("err_count",  int'(err_count),  m_cnt16);
            check("locked2",    int'(locked2),    int'(m_locked));
            check("err_pulse2", int'(err_pulse2), int'(m_pulse));
            check("err_count2", int'(err_count2), m_cnt2);
        end
    end

    // Apply one cycle of inputs; returns just after the following falling edge.
    task automatic step(input bit v, input bit b, input bit c);
        bit_valid = v; bit_in = b; clear = c;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic bit model_pred();
        return m_hist[c_TAP_A-1] ^ m_hist[c_TAP_B-1];
    endfunction

    initial begin
        int nv;
        bit v;
        reset_n = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk_en = 1'b1;
        check("rst_locked",    int'(locked),    0);
        check("rst_err_pulse", int'(err_pulse), 0);
        check("rst_err_count", int'(err_count), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // 1: clean stream locks one cycle after valid bit 11.
        ph = 0;
        for (int i = 0; i < 110; i++) begin
            step(1'b1, stream[ph % 7], 1'b0);
            ph++;
            if (i == 9)  check("t1_unlocked_bit10", int'(locked), 0);
            if (i == 10) check("t1_locked_bit11",   int'(locked), 1);
        end
        check("t1_err_count", int'(err_count), 0);

        // 2: a single inverted bit yields three errors via the taps.
        step(1'b1, ~stream[ph % 7], 1'b0);
        ph++;
        check("t2_first_pulse", int'(err_pulse), 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, stream[ph % 7], 1'b0);
            ph++;
        end
        check("t2_err_count", int'(err_count), 3);
        check("t2_locked",    int'(locked), 1);

        // 3: four bits opposite to the prediction force loss of lock.
        // Avoid the one history that would leave the register all-zero.
        if (m_hist[0] == 1'b0 && m_hist[1] == 1'b1 && m_hist[2] == 1'b1) begin
            step(1'b1, stream[ph % 7], 1'b0);
            ph++;
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, ~model_pred(), 1'b0);
            if (k == 2) check("t3_still_locked", int'(locked), 1);
        end
        check("t3_unlocked",   int'(locked), 0);
        check("t3_err_count",  int'(err_count), 7);
        check("t3_err_count2", int'(err_count2), 3);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, model_pred(), 1'b0);
            if (k == 6) check("t3_relock_early", int'(locked), 0);
        end
        check("t3_relocked", int'(locked), 1);

        // 4: all-zero stream never locks.
        do_reset();
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 1'b0);
        check("t4_locked",    int'(locked), 0);
        check("t4_err_count", int'(err_count), 0);

        // 5: random bit_valid; lock point counted in valid bits.
        do_reset();
        nv = 0; ph = 0;
        for (int i = 0; i < 400 && nv < 24; i++) begin
            v = 1'($urandom_range(0, 1));
            step(v, v ? stream[ph % 7] : 1'($urandom_range(0, 1)), 1'b0);
            if (v) begin
                nv++; ph++;
                if (nv == 10) check("t5_unlocked_bit10", int'(locked), 0);
                if (nv == 11) check("t5_locked_bit11",   int'(locked), 1);
            end else begin
                check("t5_idle_pulse", int'(err_pulse), 0);
            end
        end
        check("t5_valid_budget", (nv >= 24) ? 1 : 0, 1);

        // 6: saturation of the 2-bit counter, clear vs error, async reset.
        do_reset();
        ph = 0;
        for (int i = 0; i < 20; i++) begin step(1'b1, stream[ph % 7], 1'b0); ph++; end
        for (int e = 0; e < 2; e++) begin
            step(1'b1, ~stream[ph % 7], 1'b0); ph++;
            for (int i = 0; i < 5; i++) begin step(1'b1, stream[ph % 7], 1'b0); ph++; end
        end
        check("t6_err_count",  int'(err_count), 6);
        check("t6_err_count2", int'(err_count2), 3);
        step(1'b1, ~stream[ph % 7], 1'b1); ph++;
        check("t6_clear_pulse",  int'(err_pulse), 1);
        check("t6_clear_count",  int'(err_count), 0);
        check("t6_clear_count2", int'(err_count2), 0);
        for (int i = 0; i < 5; i++) begin step(1'b1, stream[ph % 7], 1'b0); ph++; end
        check("t6_after_clear", int'(err_count), 2);
        check("t6_locked",      int'(locked), 1);
        reset_n = 1'b0;
        #1;
        check("t6_async_locked",  int'(locked), 0);
        check("t6_async_count",   int'(err_count), 0);
        check("t6_async_count2",  int'(err_count2), 0);
        check("t6_async_locked2", int'(locked2), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
